// File: rtl/sdff_pipe_ift.sv
// sdff_pipe_ift: taint-tracked shift/load register pipeline with fill counter.
// Define SDFF_PIPE_CTRL_TAINT_EN to fold clock/control taint (implicit flows) into every stage update.
module sdff_pipe_ift #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int TAINT_W = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         CLK,
  input  logic [TAINT_W-1:0]           CLK_t,
  input  logic                         RST,
  input  logic [TAINT_W-1:0]           RST_t,
  input  logic                         EN,
  input  logic [TAINT_W-1:0]           EN_t,
  input  logic                         ALOAD,
  input  logic [TAINT_W-1:0]           ALOAD_t,
  input  logic [WIDTH-1:0]             AD,
  input  logic [TAINT_W-1:0]           AD_t,
  input  logic [WIDTH-1:0]             D,
  input  logic [TAINT_W-1:0]           D_t,
  output logic [WIDTH-1:0]             Q,
  output logic [TAINT_W-1:0]           Q_t,
  output logic [$clog2(DEPTH+1)-1:0]   FILL,
  output logic                         VALID
);
  localparam int FW = $clog2(DEPTH+1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  logic [WIDTH-1:0]   r_data  [DEPTH];
  logic [TAINT_W-1:0] r_taint [DEPTH];
  logic [FW-1:0]      r_fill;
  logic [TAINT_W-1:0] w_c_rst, w_c_load, w_c_en, w_c_hold;
`ifdef SDFF_PIPE_CTRL_TAINT_EN
  assign w_c_rst  = CLK_t | RST_t;
  assign w_c_load = CLK_t | ALOAD_t;
  assign w_c_en   = CLK_t | EN_t;
  assign w_c_hold = CLK_t | EN_t | ALOAD_t;
`else
  logic [TAINT_W-1:0] w_unused_ctrl_t;
  assign w_unused_ctrl_t = CLK_t ^ RST_t ^ EN_t ^ ALOAD_t;
  assign w_c_rst  = '0;
  assign w_c_load = '0;
  assign w_c_en   = '0;
  assign w_c_hold = '0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i]  <= RST_VAL;
        r_taint[i] <= w_c_rst;
      end
      r_fill <= '0;
    end else if (ALOAD) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i]  <= AD;
        r_taint[i] <= AD_t | w_c_load;
      end
      r_fill <= FULL;
    end else if (EN) begin
      r_data[0]  <= D;
      r_taint[0] <= D_t | w_c_en;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_taint[i] <= r_taint[i-1] | w_c_en;
      end
      r_fill <= (r_fill == FULL) ? r_fill : r_fill + 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_taint[i] <= r_taint[i] | w_c_hold;
    end
  end
  assign Q     = r_data[DEPTH-1];
  assign Q_t   = r_taint[DEPTH-1];
  assign FILL  = r_fill;
  assign VALID = (r_fill == FULL);
endmodule

// File: tb/tb_sdff_pipe_ift.sv
// tb_sdff_pipe_ift: scoreboard bench for sdff_pipe_ift against a queue-based pipeline model.
module tb_sdff_pipe_ift;
  localparam int W = 2, N = 4, TW = 32;
  localparam logic [W-1:0] RV = 2'b10;
  typedef struct {
    logic [W-1:0]  q;
    logic [TW-1:0] qt;
    logic [2:0]    fill;
    logic          valid;
  } exp_t;
  logic clk = 0;
  logic rst = 0, en = 0, aload = 0;
  logic [W-1:0] ad = 0, d = 0;
  logic [TW-1:0] clk_t = 0, rst_t = 0, en_t = 0, aload_t = 0, ad_t = 0, d_t = 0;
  logic [W-1:0] q;
  logic [TW-1:0] q_t;
  logic [2:0] fill;
  logic valid;
  exp_t sb[$];
  logic [W-1:0]  m_d[$];
  logic [TW-1:0] m_t[$];
  int m_fill = 0;
  int errors = 0, checks = 0;
  bit done = 0;
  sdff_pipe_ift #(.WIDTH(W), .DEPTH(N), .TAINT_W(TW), .RST_VAL(RV)) dut (
    .CLK(clk), .CLK_t(clk_t), .RST(rst), .RST_t(rst_t), .EN(en), .EN_t(en_t),
    .ALOAD(aload), .ALOAD_t(aload_t), .AD(ad), .AD_t(ad_t), .D(d), .D_t(d_t),
    .Q(q), .Q_t(q_t), .FILL(fill), .VALID(valid)
  );
  always #5 clk = ~clk;
  function automatic logic [TW-1:0] ctl(input logic [TW-1:0] t);
`ifdef SDFF_PIPE_CTRL_TAINT_EN
    return clk_t | t;
`else
    return '0;
`endif
  endfunction
  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Model: stage 0 at the queue front, Q at the back; shift = push_front + pop_back.
  task automatic model_edge();
    logic [TW-1:0] c;
    exp_t e;
    if (rst) begin
      c = ctl(rst_t);
      foreach (m_d[i]) begin m_d[i] = RV; m_t[i] = c; end
      m_fill = 0;
    end else if (aload) begin
      c = ctl(aload_t);
      foreach (m_d[i]) begin m_d[i] = ad; m_t[i] = ad_t | c; end
      m_fill = N;
    end else if (en) begin
      c = ctl(en_t);
      foreach (m_t[i]) m_t[i] |= c;
      m_d.push_front(d);
      m_t.push_front(d_t | c);
      void'(m_d.pop_back());
      void'(m_t.pop_back());
      m_fill = (m_fill + 1 > N) ? N : m_fill + 1;
    end else begin
      c = ctl(en_t | aload_t);
      foreach (m_t[i]) m_t[i] |= c;
    end
    e.q = m_d[N-1];
    e.qt = m_t[N-1];
    e.fill = 3'(m_fill);
    e.valid = (m_fill == N);
    sb.push_back(e);
  endtask
  task automatic step(input logic r, input logic al, input logic e, input logic [W-1:0] a,
                      input logic [TW-1:0] at, input logic [W-1:0] dd, input logic [TW-1:0] dt);
    @(negedge clk);
    rst = r; aload = al; en = e; ad = a; ad_t = at; d = dd; d_t = dt;
    @(posedge clk);
    model_edge();
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("Q", TW'(q), TW'(e.q));
      chk("Q_t", q_t, e.qt);
      chk("FILL", TW'(fill), TW'(e.fill));
      chk("VALID", TW'(valid), TW'(e.valid));
    end
  end
  initial begin
    for (int i = 0; i < N; i++) begin m_d.push_back('x); m_t.push_back('x); end
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 2'b01, 32'h1);
    step(0, 0, 1, 0, 0, 2'b10, 0);
    step(0, 0, 1, 0, 0, 2'b11, 0);
    step(0, 0, 1, 0, 0, 2'b00, 0);
    @(negedge clk);
    chk("shift_Q", TW'(q), 32'h1);
    chk("shift_Qt", q_t, 32'h1);
    chk("shift_VALID", TW'(valid), 32'h1);
    step(0, 1, 0, 2'b11, 32'h4, 0, 0);
    step(0, 1, 1, 2'b10, 0, 2'b01, 32'h2);
    step(0, 0, 1, 0, 0, 2'b01, 0);
    step(0, 0, 1, 0, 0, 2'b11, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrst_FILL", TW'(fill), 32'h0);
    chk("midrst_Q", TW'(q), TW'(RV));
    step(0, 1, 0, 2'b01, 32'h10, 0, 0);
    @(negedge clk);
    en_t = 32'h8;
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef SDFF_PIPE_CTRL_TAINT_EN
    chk("hold_ctrl_taint", q_t, 32'h18);
`else
    chk("hold_ctrl_taint", q_t, 32'h10);
`endif
    en_t = 0;
    for (int k = 0; k < 400; k++) begin
      clk_t = ($urandom_range(0, 7) == 0) ? TW'(1) << $urandom_range(0, TW - 1) : '0;
      en_t = ($urandom_range(0, 3) == 0) ? $urandom : '0;
      aload_t = ($urandom_range(0, 3) == 0) ? $urandom : '0;
      rst_t = ($urandom_range(0, 3) == 0) ? $urandom : '0;
      step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           W'($urandom), ($urandom_range(0, 1) == 1) ? $urandom : '0,
           W'($urandom), ($urandom_range(0, 1) == 1) ? $urandom : '0);
    end
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
    end
    done = 1;
  end
  initial begin
    fork
      wait (done);
      #100000;
    join_any
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete, expected completion");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
